// File: rtl/hwint_ctrl_if.sv
// hwint_ctrl_if: processor-bridge register port for the interrupt controller.
// Rev 1.0
`default_nettype none

interface hwint_ctrl_if;
  logic        sel;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, we, re, wdata, input rdata);
  modport slave  (input sel, addr, we, re, wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/hwint_ctrl.sv
// hwint_ctrl: maskable, nesting, fixed-priority interrupt controller driving HWInt[7:2].
// Optional HWINT_SYNC_EN adds a 2-flop input synchronizer. Rev 1.0
`default_nettype none

module hwint_ctrl #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  hwint_ctrl_if.slave     bus,
  output logic [5:0]      HWInt
);

  localparam logic [2:0] C_NO_ID   = 3'd7;
  localparam logic [1:0] C_A_PEND  = 2'd0;
  localparam logic [1:0] C_A_MASK  = 2'd1;
  localparam logic [1:0] C_A_MODE  = 2'd2;
  localparam logic [1:0] C_A_CLAIM = 2'd3;

  logic [NSRC-1:0] r_pend, r_mask, r_mode, r_isr, r_src_q;
  logic [5:0]      r_hwint;
  logic [NSRC-1:0] w_src, w_edge, w_wd, w_w1c, w_clm_oh, w_eoi_oh, w_pend_nxt;
  logic [5:0]      w_elig;
  logic [2:0]      w_claim_id;
  logic [31:0]     w_rdata;
  logic            w_wr_pend, w_wr_mask, w_wr_mode, w_claim, w_eoi;
  logic            w_unused;

`ifdef HWINT_SYNC_EN
  logic [NSRC-1:0] r_sync1, r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_src;
`endif

  assign w_edge    = w_src & ~r_src_q;
  assign w_wd      = bus.wdata[NSRC-1:0];
  assign w_unused  = ^bus.wdata;
  assign w_wr_pend = bus.sel & bus.we & (bus.addr == C_A_PEND);
  assign w_wr_mask = bus.sel & bus.we & (bus.addr == C_A_MASK);
  assign w_wr_mode = bus.sel & bus.we & (bus.addr == C_A_MODE);
  assign w_claim   = bus.sel & bus.re & (bus.addr == C_A_CLAIM);
  assign w_eoi     = bus.sel & bus.we & (bus.addr == C_A_CLAIM);

  // Any in-service source at equal or higher priority blocks source i.
  always_comb begin
    logic v_blk;
    logic v_found;
    v_blk      = 1'b0;
    v_found    = 1'b0;
    w_elig     = '0;
    w_claim_id = C_NO_ID;
    for (int i = 0; i < NSRC; i++) begin
      v_blk     = v_blk | r_isr[i];
      w_elig[i] = r_pend[i] & r_mask[i] & ~v_blk;
      if (w_elig[i] && !v_found) begin
        v_found    = 1'b1;
        w_claim_id = 3'(i);
      end
    end
  end

  always_comb begin
    w_clm_oh = '0;
    w_eoi_oh = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_clm_oh[i] = w_claim & (w_claim_id == 3'(i));
      w_eoi_oh[i] = w_eoi & (bus.wdata[2:0] == 3'(i));
    end
  end

  // Edge sources hold until W1C or claim (a new edge wins); level sources mirror the input.
  assign w_w1c      = w_wr_pend ? w_wd : '0;
  assign w_pend_nxt = (r_mode & (w_edge | (r_pend & ~w_w1c & ~w_clm_oh)))
                    | (~r_mode & w_src);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend  <= '0;
      r_mask  <= '0;
      r_mode  <= '0;
      r_isr   <= '0;
      r_src_q <= '0;
      r_hwint <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_src_q <= w_src;
      r_isr   <= (r_isr & ~w_eoi_oh) | w_clm_oh;
      r_hwint <= w_elig;
      if (w_wr_mask) r_mask <= w_wd;
      if (w_wr_mode) r_mode <= w_wd;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.sel) begin
      case (bus.addr)
        C_A_PEND:  w_rdata[NSRC-1:0] = r_pend;
        C_A_MASK:  w_rdata[NSRC-1:0] = r_mask;
        C_A_MODE:  w_rdata[NSRC-1:0] = r_mode;
        default:   w_rdata[2:0]      = w_claim_id;
      endcase
    end
  end

  assign bus.rdata = w_rdata;
  assign HWInt     = r_hwint;

endmodule

`default_nettype wire

// File: tb/tb_hwint_ctrl.sv
// tb_hwint_ctrl: scoreboard bench for hwint_ctrl; expectations queued by stimulus, checked by a monitor.
`default_nettype none

module tb_hwint_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] irq_src;
  logic [5:0] HWInt;

  hwint_ctrl_if bus_if();

  hwint_ctrl #(.NSRC(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .bus     (bus_if),
    .HWInt   (HWInt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  bit          smp = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        m_e;
  logic [31:0] m_act;

  // kind 0 compares rdata, kind 1 compares HWInt
  always @(negedge clk) begin
    if (smp) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: sample with no expected entry");
      end else begin
        m_e   = sb.pop_front();
        m_act = m_e.kind ? {26'd0, HWInt} : bus_if.rdata;
        if (m_act !== m_e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", m_e.nm, m_act, m_e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus_if.sel  = 1'b1;
    bus_if.re   = 1'b1;
    bus_if.addr = a;
    sb.push_back('{1'b0, e, nm});
    smp = 1'b1;
    tick();
    smp = 1'b0;
    bus_if.sel = 1'b0;
    bus_if.re  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.sel   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    tick();
    bus_if.sel   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.wdata = '0;
  endtask

  task automatic chk_hw(input logic [5:0] e, input string nm);
    sb.push_back('{1'b1, {26'd0, e}, nm});
    smp = 1'b1;
    tick();
    smp = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] m);
    irq_src = m;
    tick();
    irq_src = '0;
    tick();
  endtask

  initial begin
    bus_if.sel   = 1'b0;
    bus_if.re    = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;
    irq_src      = 6'h3F;
    rst          = 1'b0;
    tick();

    chk_hw(6'h00, "rst_hwint");
    rd(2'd0, 32'h0, "rst_pend");
    rd(2'd1, 32'h0, "rst_mask");
    rd(2'd2, 32'h0, "rst_mode");
    rd(2'd3, 32'h7, "rst_claim");
    irq_src = '0;
    tick();
    rst = 1'b1;
    tick();

    // edge latch, latency and W1C
    wr(2'd2, 32'h1);
    wr(2'd1, 32'h1);
    irq_src = 6'h01;
    tick();
    irq_src = '0;
    chk_hw(6'h00, "edge_latency");
    rd(2'd0, 32'h1, "edge_pend");
    chk_hw(6'h01, "edge_hwint");
    wr(2'd0, 32'h1);
    rd(2'd0, 32'h0, "w1c_pend");
    chk_hw(6'h00, "w1c_hwint");

    // priority and claim
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h3F);
    pulse(6'b001010);
    chk_hw(6'h0A, "prio_hwint");
    rd(2'd3, 32'h1, "claim_1");
    rd(2'd3, 32'h7, "claim_blocked");
    chk_hw(6'h00, "claim_hw_blocked");
    wr(2'd3, 32'h1);
    rd(2'd0, 32'h8, "pend_after_claim");
    chk_hw(6'h08, "eoi1_hwint");
    rd(2'd3, 32'h3, "claim_3");

    // nesting
    pulse(6'b010000);
    chk_hw(6'h00, "nest_blocked");
    pulse(6'b000001);
    chk_hw(6'h01, "nest_higher");
    wr(2'd3, 32'h6);
    wr(2'd3, 32'h7);
    chk_hw(6'h01, "eoi_bad_id");
    wr(2'd3, 32'h3);
    chk_hw(6'h01, "eoi3_latency");
    chk_hw(6'h11, "eoi3_hwint");
    rd(2'd3, 32'h0, "claim_0");
    rd(2'd3, 32'h7, "claim_none");
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h4, "claim_4");
    wr(2'd3, 32'h4);

    // edge set beats W1C in the same cycle
    irq_src = 6'h20;
    wr(2'd0, 32'h20);
    irq_src = '0;
    rd(2'd0, 32'h20, "edge_w1c_set_wins");
    wr(2'd0, 32'h20);
    rd(2'd0, 32'h0, "w1c_clear_5");

    // level mode and mask
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h0);
    irq_src = 6'h04;
    tick();
    tick();
    rd(2'd0, 32'h4, "lvl_pend");
    chk_hw(6'h00, "lvl_masked");
    wr(2'd0, 32'h4);
    rd(2'd0, 32'h4, "lvl_w1c_no_effect");
    wr(2'd1, 32'h4);
    chk_hw(6'h00, "lvl_mask_latency");
    chk_hw(6'h04, "lvl_unmasked");
    irq_src = '0;
    chk_hw(6'h04, "lvl_drop_0");
    chk_hw(6'h04, "lvl_drop_1");
    chk_hw(6'h00, "lvl_drop_2");

    // asynchronous reset mid-operation
    irq_src = 6'h04;
    tick();
    tick();
    chk_hw(6'h04, "pre_rst_hwint");
    rst = 1'b0;
    chk_hw(6'h00, "async_rst_hwint");
    rd(2'd1, 32'h0, "async_rst_mask");
    irq_src = '0;
    tick();
    rst = 1'b1;
    tick();
    rd(2'd3, 32'h7, "post_rst_claim");

    tick();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
